// File: rtl/vld_unit.sv
// Vector load sequencer: fetches 1..16 strided 16-bit elements from data
// memory one request per cycle, packs them into a 256-bit vector and commits
// it to the vector register file in a single write cycle.
module vld_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        vd,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [3:0]        len,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [15:0]       mem_rdata,
  output logic              vreg_wEn,
  output logic [3:0]        vreg_wAddr,
  output logic [3:0]        vreg_wLen,
  output logic [255:0]      vreg_wData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          vd_q, vd_d;
  logic [3:0]          len_q, len_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          k_q, k_d;
  logic [255:0]        buf_q, buf_d;

  logic                slot_wr;
  logic [3:0]          slot_idx;

  // Next-state, command latching and element capture into the assembly buffer.
  // Data for the request issued at k arrives one cycle later, so FETCH stores
  // into slot k-1 and DRAIN stores the last element into slot len.
  always_comb begin
    state_d  = state_q;
    vd_d     = vd_q;
    len_d    = len_q;
    stride_d = stride_q;
    addr_d   = addr_q;
    k_d      = k_q;
    buf_d    = buf_q;
    slot_wr  = 1'b0;
    slot_idx = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          vd_d     = vd;
          len_d    = len;
          stride_d = stride;
          addr_d   = base;
          k_d      = '0;
          buf_d    = '0;
        end
      end
      S_FETCH: begin
        addr_d = addr_q + stride_q;
        if (k_q != 4'd0) begin
          slot_wr  = 1'b1;
          slot_idx = k_q - 4'd1;
        end
        if (k_q == len_q) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_DRAIN: begin
        slot_wr  = 1'b1;
        slot_idx = len_q;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (slot_wr) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (slot_idx == 4'(i)) begin
          buf_d[16*i +: 16] = mem_rdata;
        end
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vd_q     <= '0;
      len_q    <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      k_q      <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      vd_q     <= vd_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      buf_q    <= buf_d;
    end
  end

  // Outputs decode from registered state only; write-port fields are zero
  // whenever no write is in progress.
  always_comb begin
    busy       = (state_q != S_IDLE);
    mem_ren    = (state_q == S_FETCH);
    mem_raddr  = mem_ren ? addr_q : '0;
    vreg_wEn   = (state_q == S_WRITE);
    done       = vreg_wEn;
    vreg_wAddr = vreg_wEn ? vd_q  : '0;
    vreg_wLen  = vreg_wEn ? len_q : '0;
    vreg_wData = vreg_wEn ? buf_q : '0;
  end

endmodule

// File: tb/tb_vld_unit.sv
// Directed testbench for vld_unit with a one-cycle-latency memory model.
module tb_vld_unit;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    vd;
  logic [15:0]   base;
  logic [15:0]   stride;
  logic [3:0]    len;
  logic          busy;
  logic          done;
  logic          mem_ren;
  logic [15:0]   mem_raddr;
  logic [15:0]   mem_rdata = '0;
  logic          vreg_wEn;
  logic [3:0]    vreg_wAddr;
  logic [3:0]    vreg_wLen;
  logic [255:0]  vreg_wData;

  int tests = 0;
  int fails = 0;

  logic [15:0]   mem_key = '0;

  logic [15:0]   req_addr [0:31];
  int            req_cyc  [0:31];
  int            req_cnt;
  int            wen_count;
  int            wen_cyc;
  logic [3:0]    obs_waddr;
  logic [3:0]    obs_wlen;
  logic [255:0]  obs_wdata;
  int            busy_err;
  int            done_err;
  logic          zero_ok;

  vld_unit #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vd         (vd),
    .base       (base),
    .stride     (stride),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .vreg_wEn   (vreg_wEn),
    .vreg_wAddr (vreg_wAddr),
    .vreg_wLen  (vreg_wLen),
    .vreg_wData (vreg_wData)
  );

  always #5 clk = ~clk;

  // memory[a] = a ^ mem_key, data valid the cycle after the request
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_raddr ^ mem_key;
  end

  function automatic logic [255:0] expected_vec(input logic [15:0] b, input logic [15:0] s,
                                                input int n, input logic [15:0] key);
    logic [255:0] v;
    logic [15:0]  a;
    v = '0;
    for (int i = 0; i < n; i++) begin
      a = b + 16'(i * s);
      v[16*i +: 16] = a ^ key;
    end
    return v;
  endfunction

  // Issues a start in the current cycle (cycle 0) and records outputs in cycles 1..maxc.
  // sb1/sb2: cycles with a spurious start (different vd); rst_cyc: cycle with rst_n low.
  task automatic do_load(input logic [3:0] t_vd, input logic [15:0] t_base,
                         input logic [15:0] t_stride, input logic [3:0] t_len,
                         input int sb1, input int sb2, input int rst_cyc, input int maxc);
    int  n;
    logic exp_busy;
    n = int'(t_len) + 1;
    req_cnt = 0; wen_count = 0; wen_cyc = -1; busy_err = 0; done_err = 0; zero_ok = 1'b0;
    obs_waddr = '0; obs_wlen = '0; obs_wdata = '0;
    vd = t_vd; base = t_base; stride = t_stride; len = t_len; start = 1'b1; rst_n = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk); #1;
      start = 1'b0; rst_n = 1'b1;
      vd = ~t_vd; base = 16'($urandom); stride = 16'($urandom); len = ~t_len;
      if (c == sb1 || c == sb2) begin
        start = 1'b1;
        vd    = t_vd ^ 4'h5;
      end
      if (c == rst_cyc) rst_n = 1'b0;
      if (mem_ren) begin
        if (req_cnt < 32) begin
          req_addr[req_cnt] = mem_raddr;
          req_cyc[req_cnt]  = c;
        end
        req_cnt++;
      end
      if (vreg_wEn) begin
        if (wen_count == 0) begin
          wen_cyc = c; obs_waddr = vreg_wAddr; obs_wlen = vreg_wLen; obs_wdata = vreg_wData;
        end
        wen_count++;
      end
      if (done !== vreg_wEn) done_err++;
      exp_busy = (rst_cyc < 0) ? (c <= n + 2) : (c <= rst_cyc);
      if (busy !== exp_busy) busy_err++;
      if (rst_cyc >= 0 && c == rst_cyc + 1)
        zero_ok = ({busy, done, mem_ren, mem_raddr, vreg_wEn, vreg_wAddr, vreg_wLen} == '0) &&
                  (vreg_wData == '0);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; vd = 4'hA; base = 16'h1234; stride = 16'h0002; len = 4'h5;
    repeat (2) begin @(posedge clk); #1; end
    tests++;
    if ({busy, done, mem_ren, mem_raddr, vreg_wEn, vreg_wAddr, vreg_wLen} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl got busy=%b done=%b ren=%b raddr=%h wen=%b waddr=%h wlen=%h exp all 0",
               busy, done, mem_ren, mem_raddr, vreg_wEn, vreg_wAddr, vreg_wLen);
    end
    tests++;
    if (vreg_wData !== '0) begin
      fails++;
      $display("FAIL reset_wdata got %h exp 0", vreg_wData);
    end
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_unit_stride();
    logic [255:0] exp;
    mem_key = 16'h0000;
    exp = expected_vec(16'h0100, 16'h0001, 16, 16'h0000);
    do_load(4'd3, 16'h0100, 16'h0001, 4'd15, -1, -1, -1, 20);
    tests++;
    if (req_cnt !== 16) begin fails++; $display("FAIL unit_req_cnt got %0d exp 16", req_cnt); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (req_addr[i] !== 16'(16'h0100 + i) || req_cyc[i] !== i + 1) begin
        fails++;
        $display("FAIL unit_req[%0d] got addr=%h cyc=%0d exp addr=%h cyc=%0d",
                 i, req_addr[i], req_cyc[i], 16'(16'h0100 + i), i + 1);
      end
    end
    tests++;
    if (wen_count !== 1 || wen_cyc !== 18) begin
      fails++; $display("FAIL unit_wen got count=%0d cyc=%0d exp count=1 cyc=18", wen_count, wen_cyc);
    end
    tests++;
    if (obs_waddr !== 4'd3 || obs_wlen !== 4'd15) begin
      fails++; $display("FAIL unit_waddr_wlen got %h/%h exp 3/f", obs_waddr, obs_wlen);
    end
    tests++;
    if (obs_wdata !== exp) begin
      fails++; $display("FAIL unit_wdata got %h exp %h", obs_wdata, exp);
    end
    tests++;
    if (busy_err !== 0 || done_err !== 0) begin
      fails++; $display("FAIL unit_busy_done got busy_err=%0d done_err=%0d exp 0/0", busy_err, done_err);
    end
  endtask

  task automatic test_strided();
    logic [255:0] exp;
    mem_key = 16'h5A00;
    exp = expected_vec(16'h0010, 16'h0004, 3, 16'h5A00);
    do_load(4'd7, 16'h0010, 16'h0004, 4'd2, -1, -1, -1, 7);
    tests++;
    if (req_cnt !== 3 || req_addr[0] !== 16'h0010 || req_addr[1] !== 16'h0014 || req_addr[2] !== 16'h0018) begin
      fails++;
      $display("FAIL stride_addrs got cnt=%0d %h %h %h exp 3 0010 0014 0018",
               req_cnt, req_addr[0], req_addr[1], req_addr[2]);
    end
    tests++;
    if (obs_wdata !== exp) begin
      fails++; $display("FAIL stride_wdata got %h exp %h", obs_wdata, exp);
    end
    tests++;
    if (wen_cyc !== 5 || done_err !== 0 || obs_waddr !== 4'd7 || obs_wlen !== 4'd2) begin
      fails++;
      $display("FAIL stride_done got cyc=%0d done_err=%0d waddr=%h wlen=%h exp 5 0 7 2",
               wen_cyc, done_err, obs_waddr, obs_wlen);
    end
  endtask

  task automatic test_wrap_zero_stride();
    logic [255:0] exp;
    mem_key = 16'h1234;
    exp = expected_vec(16'hFFFE, 16'h0001, 4, 16'h1234);
    do_load(4'd4, 16'hFFFE, 16'h0001, 4'd3, -1, -1, -1, 8);
    tests++;
    if (req_cnt !== 4 || req_addr[0] !== 16'hFFFE || req_addr[1] !== 16'hFFFF ||
        req_addr[2] !== 16'h0000 || req_addr[3] !== 16'h0001) begin
      fails++;
      $display("FAIL wrap_addrs got cnt=%0d %h %h %h %h exp 4 fffe ffff 0000 0001",
               req_cnt, req_addr[0], req_addr[1], req_addr[2], req_addr[3]);
    end
    tests++;
    if (obs_wdata !== exp) begin
      fails++; $display("FAIL wrap_wdata got %h exp %h", obs_wdata, exp);
    end
    exp = expected_vec(16'h0042, 16'h0000, 2, 16'h1234);
    do_load(4'd8, 16'h0042, 16'h0000, 4'd1, -1, -1, -1, 6);
    tests++;
    if (req_cnt !== 2 || req_addr[0] !== 16'h0042 || req_addr[1] !== 16'h0042) begin
      fails++;
      $display("FAIL zstride_addrs got cnt=%0d %h %h exp 2 0042 0042", req_cnt, req_addr[0], req_addr[1]);
    end
    tests++;
    if (obs_wdata !== exp) begin
      fails++; $display("FAIL zstride_wdata got %h exp %h", obs_wdata, exp);
    end
  endtask

  task automatic test_start_busy();
    logic [255:0] exp;
    mem_key = 16'h00FF;
    exp = expected_vec(16'h0300, 16'h0002, 16, 16'h00FF);
    do_load(4'd9, 16'h0300, 16'h0002, 4'd15, 2, 18, -1, 22);
    tests++;
    if (wen_count !== 1 || obs_waddr !== 4'd9) begin
      fails++; $display("FAIL busy_start_wen got count=%0d waddr=%h exp 1 9", wen_count, obs_waddr);
    end
    tests++;
    if (obs_wdata !== exp || req_cnt !== 16) begin
      fails++; $display("FAIL busy_start_data got req=%0d wdata=%h exp 16 %h", req_cnt, obs_wdata, exp);
    end
    tests++;
    if (busy_err !== 0) begin
      fails++; $display("FAIL busy_start_busy got busy_err=%0d exp 0", busy_err);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [255:0] exp;
    mem_key = 16'hC000;
    do_load(4'd5, 16'h0400, 16'h0001, 4'd7, -1, -1, 5, 12);
    tests++;
    if (wen_count !== 0) begin
      fails++; $display("FAIL rstmid_wen got count=%0d exp 0", wen_count);
    end
    tests++;
    if (zero_ok !== 1'b1 || busy_err !== 0) begin
      fails++; $display("FAIL rstmid_outputs got zero_ok=%b busy_err=%0d exp 1 0", zero_ok, busy_err);
    end
    exp = expected_vec(16'h0500, 16'h0003, 2, 16'hC000);
    do_load(4'd6, 16'h0500, 16'h0003, 4'd1, -1, -1, -1, 6);
    tests++;
    if (wen_cyc !== 3 + 1 || obs_waddr !== 4'd6 || obs_wdata !== exp) begin
      fails++;
      $display("FAIL rstmid_reload got cyc=%0d waddr=%h wdata=%h exp 4 6 %h", wen_cyc, obs_waddr, obs_wdata, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp;
    mem_key = 16'h0A0A;
    // first command: start in cycle 0, write in cycle 3, next start in cycle 4
    exp = expected_vec(16'h0600, 16'h0001, 1, 16'h0A0A);
    do_load(4'd1, 16'h0600, 16'h0001, 4'd0, -1, -1, -1, 4);
    tests++;
    if (wen_count !== 1 || wen_cyc !== 3 || obs_waddr !== 4'd1 || obs_wdata !== exp) begin
      fails++;
      $display("FAIL b2b_first got count=%0d cyc=%0d waddr=%h wdata=%h exp 1 3 1 %h",
               wen_count, wen_cyc, obs_waddr, obs_wdata, exp);
    end
    // second command starts in absolute cycle 4, so its write lands in cycle 7
    exp = expected_vec(16'h0700, 16'h0005, 1, 16'h0A0A);
    do_load(4'd2, 16'h0700, 16'h0005, 4'd0, -1, -1, -1, 5);
    tests++;
    if (wen_count !== 1 || wen_cyc + 4 !== 7 || obs_waddr !== 4'd2 || obs_wdata !== exp) begin
      fails++;
      $display("FAIL b2b_second got count=%0d abs_cyc=%0d waddr=%h wdata=%h exp 1 7 2 %h",
               wen_count, wen_cyc + 4, obs_waddr, obs_wdata, exp);
    end
    tests++;
    if (busy_err !== 0 || done_err !== 0) begin
      fails++; $display("FAIL b2b_busy_done got %0d/%0d exp 0/0", busy_err, done_err);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vd = '0; base = '0; stride = '0; len = '0;
    @(posedge clk); #1;
    test_reset();
    test_unit_stride();
    test_strided();
    test_wrap_zero_stride();
    test_start_busy();
    test_reset_mid_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
